// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake: head-of-queue instruction, its PC and PC+4,
// qualified by valid and accepted by ready.
interface instruction_fetch_queue_if #(
  parameter int LEN = 32
);
  logic           in_ready;
  logic           out_valid;
  logic [LEN-1:0] out_instruction;
  logic [LEN-1:0] out_pc;
  logic [LEN-1:0] out_pc_branch;

  modport master (
    input  in_ready,
    output out_valid,
    output out_instruction,
    output out_pc,
    output out_pc_branch
  );

  modport slave (
    output in_ready,
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    input  out_pc_branch
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch: PC select, 1-cycle synchronous instruction RAM, and a small
// queue to decode. Define IF_PROGRAM_LOAD_EN to add the debug program-load write port.
module instruction_fetch_queue #(
  parameter int             LEN        = 32,
  parameter int             ADDR_W     = 11,
  parameter int             FIFO_DEPTH = 4,
  parameter logic [LEN-1:0] PC_RESET   = '0,
  parameter string          INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          in_pc_src,
  input  logic [LEN-1:0]      in_pc_jump,
  input  logic [LEN-1:0]      in_pc_branch,
  input  logic [LEN-1:0]      in_pc_register,
`ifdef IF_PROGRAM_LOAD_EN
  input  logic                in_load_we,
  input  logic [ADDR_W-1:0]   in_load_addr,
  input  logic [LEN-1:0]      in_load_data,
`endif
  instruction_fetch_queue_if.master dec
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 2;

  logic [LEN-1:0]    mem [2**ADDR_W];
  logic [LEN-1:0]    q_instr [FIFO_DEPTH];
  logic [LEN-1:0]    q_pc [FIFO_DEPTH];

  logic [LEN-1:0]    pc;
  logic [LEN-1:0]    inflight_pc;
  logic [LEN-1:0]    ram_q;
  logic [LEN-1:0]    target_raw;
  logic [LEN-1:0]    target;
  logic              inflight;
  logic              redirect;
  logic              issue;
  logic              push;
  logic              pop;
  logic              load_we;
  logic              head_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  push_c;
  logic [CNT_W-1:0]  pop_c;
  logic [CNT_W-1:0]  inflight_c;
  logic [ADDR_W-1:0] raddr;

`ifdef IF_PROGRAM_LOAD_EN
  assign load_we = in_load_we;
`else
  assign load_we = 1'b0;
`endif

  always_comb begin
    target_raw = '0;
    redirect   = 1'b0;
    case (in_pc_src)
      3'b001:  begin target_raw = in_pc_jump;     redirect = 1'b1; end
      3'b010:  begin target_raw = in_pc_branch;   redirect = 1'b1; end
      3'b100:  begin target_raw = in_pc_register; redirect = 1'b1; end
      default: begin target_raw = '0;             redirect = 1'b0; end
    endcase
  end

  assign target     = {target_raw[LEN-1:2], 2'b00};
  assign raddr      = pc[ADDR_W+1:2];
  assign head_valid = (count != '0);
  assign pop        = head_valid && dec.in_ready;
  assign push       = inflight && !redirect;

  assign push_c     = {{(CNT_W-1){1'b0}}, push};
  assign pop_c      = {{(CNT_W-1){1'b0}}, pop};
  assign inflight_c = {{(CNT_W-1){1'b0}}, inflight};

  // The in-flight read already owns a slot, so it counts toward occupancy.
  assign occupancy  = count + inflight_c - pop_c;
  assign issue      = !redirect && !load_we && (occupancy < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      pc       <= target;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + LEN'(4);
        inflight_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + push_c - pop_c;
    end
  end

  always_ff @(posedge clk) begin
`ifdef IF_PROGRAM_LOAD_EN
    if (in_load_we) mem[in_load_addr] <= in_load_data;
`endif
    if (issue) ram_q <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= ram_q;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  assign dec.out_valid       = head_valid;
  assign dec.out_instruction = head_valid ? q_instr[rd_ptr] : '0;
  assign dec.out_pc          = head_valid ? q_pc[rd_ptr] : '0;
  assign dec.out_pc_branch   = head_valid ? (q_pc[rd_ptr] + LEN'(4)) : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: sequential stream, back-pressure,
// async reset, redirect table, redirect while full, and program load when enabled.
module tb_instruction_fetch_queue;

  logic        clk;
  logic        reset;
  logic [2:0]  pc_src;
  logic [31:0] pc_jump;
  logic [31:0] pc_branch;
  logic [31:0] pc_register;
`ifdef IF_PROGRAM_LOAD_EN
  logic        load_we;
  logic [10:0] load_addr;
  logic [31:0] load_data;
`endif

  int total = 0;
  int bad   = 0;

  instruction_fetch_queue_if #(.LEN(32)) fq ();

  instruction_fetch_queue #(
    .LEN(32), .ADDR_W(11), .FIFO_DEPTH(4), .PC_RESET(32'h0), .INIT_FILE("")
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_pc_src      (pc_src),
    .in_pc_jump     (pc_jump),
    .in_pc_branch   (pc_branch),
    .in_pc_register (pc_register),
`ifdef IF_PROGRAM_LOAD_EN
    .in_load_we     (load_we),
    .in_load_addr   (load_addr),
    .in_load_data   (load_data),
`endif
    .dec            (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] jump;
    logic [31:0] branch;
    logic [31:0] register;
    logic [31:0] exp_pc;
  } redirect_vec_t;

  redirect_vec_t vecs [5];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_07FF);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc);
    chk({nm, ".valid"},  {31'b0, fq.out_valid}, 32'd1);
    chk({nm, ".pc"},     fq.out_pc, pc);
    chk({nm, ".instr"},  fq.out_instruction, instr_of(pc));
    chk({nm, ".pc4"},    fq.out_pc_branch, pc + 32'd4);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, ".valid"}, {31'b0, fq.out_valid}, 32'd0);
    chk({nm, ".pc"},    fq.out_pc, 32'd0);
    chk({nm, ".instr"}, fq.out_instruction, 32'd0);
    chk({nm, ".pc4"},   fq.out_pc_branch, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 32'h0000_0040, 32'h0000_0500, 32'h0000_0600, 32'h0000_0040};
    vecs[1] = '{3'b010, 32'h0000_0700, 32'h0000_0023, 32'h0000_0800, 32'h0000_0020};
    vecs[2] = '{3'b100, 32'h0000_0900, 32'h0000_0A00, 32'h0000_0107, 32'h0000_0104};
    vecs[3] = '{3'b001, 32'h0000_2011, 32'h0000_0B00, 32'h0000_0C00, 32'h0000_2010};
    vecs[4] = '{3'b010, 32'h0000_0D00, 32'hFFFF_FFFE, 32'h0000_0E00, 32'hFFFF_FFFC};

    reset       = 1'b1;
    pc_src      = 3'b000;
    pc_jump     = '0;
    pc_branch   = '0;
    pc_register = '0;
    fq.in_ready = 1'b1;
`ifdef IF_PROGRAM_LOAD_EN
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
`endif
    #1 reset = 1'b0;
    #1;
    chk_empty("reset0");

`ifdef IF_PROGRAM_LOAD_EN
    load_we = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      load_addr = 11'(i);
      load_data = 32'h1000_0000 + 32'(i);
      step();
    end
    load_we = 1'b0;
`else
    for (int i = 0; i < 2048; i++) dut.mem[i] = 32'h1000_0000 + 32'(i);
    step();
`endif

    // Sequential fetch: release between edges.
    #4 reset = 1'b1;
    step();
    chk("seq.first_bubble", {31'b0, fq.out_valid}, 32'd0);
    step();
    chk_head("seq.h0", 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_head($sformatf("seq.h%0d", i), 32'(4 * i));
    end

    // Async reset mid-stream, then back-pressure from a fresh start.
    step();
    #3 reset = 1'b0;
    fq.in_ready = 1'b0;
    #1;
    chk_empty("areset");
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_head("bp.hold", 32'd0);
    fq.in_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_head($sformatf("bp.h%0d", i), 32'(4 * i));
    end

    // Redirect table while streaming.
    for (int v = 0; v < 5; v++) begin
      pc_src      = vecs[v].src;
      pc_jump     = vecs[v].jump;
      pc_branch   = vecs[v].branch;
      pc_register = vecs[v].register;
      step();
      pc_src = 3'b000;
      chk($sformatf("rd%0d.r1_valid", v), {31'b0, fq.out_valid}, 32'd0);
      step();
      chk($sformatf("rd%0d.r2_valid", v), {31'b0, fq.out_valid}, 32'd0);
      step();
      chk_head($sformatf("rd%0d.r3", v), vecs[v].exp_pc);
      step();
      chk_head($sformatf("rd%0d.r4", v), vecs[v].exp_pc + 32'd4);
    end

    // Redirect while the queue is full and decode is stalled.
    fq.in_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk_head("full.hold", 32'd0);
    pc_src      = 3'b010;
    pc_jump     = 32'h0000_0044;
    pc_branch   = 32'h0000_0023;
    pc_register = 32'h0000_0088;
    step();
    pc_src = 3'b000;
    chk("full.r1_valid", {31'b0, fq.out_valid}, 32'd0);
    step();
    chk("full.r2_valid", {31'b0, fq.out_valid}, 32'd0);
    step();
    chk_head("full.r3", 32'h20);
    step();
    chk_head("full.r4_held", 32'h20);
    fq.in_ready = 1'b1;
    step();
    chk_head("full.r5", 32'h24);

    // Unlisted select code behaves as sequential.
    pc_src      = 3'b011;
    pc_jump     = 32'h0000_0300;
    pc_branch   = 32'h0000_0300;
    pc_register = 32'h0000_0300;
    step();
    pc_src = 3'b000;
    chk_head("src011.h0", 32'h28);
    step();
    chk_head("src011.h1", 32'h2C);

`ifdef IF_PROGRAM_LOAD_EN
    load_we   = 1'b1;
    load_addr = 11'd2;
    load_data = 32'hDEAD_BEEF;
    step();
    load_we = 1'b0;
    pc_src  = 3'b001;
    pc_jump = 32'h0000_0008;
    step();
    pc_src = 3'b000;
    step();
    step();
    chk("load.valid", {31'b0, fq.out_valid}, 32'd1);
    chk("load.pc", fq.out_pc, 32'h8);
    chk("load.instr", fq.out_instruction, 32'hDEAD_BEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
